// File: rtl/gzip_member_framer.sv
// gzip_member_framer: wraps a raw deflate stream in a gzip header and CRC32/ISIZE trailer.
module gzip_member_framer #(
    parameter int         INFO_AW = 2,
    parameter logic [7:0] OS_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_info_en,
    input  logic [31:0] i_info_len,
    input  logic [31:0] i_info_crc,
    input  logic        i_valid,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic        o_ready,
    output logic        o_en,
    output logic [7:0]  o_byte,
    output logic        o_eos,
    output logic        o_overflow
);
    localparam int DEPTH = 1 << INFO_AW;
    typedef enum logic [2:0] {IDLE, HEADER, BODY, WAIT_INFO, TRAILER} state_t;
    state_t               state, state_nxt;
    logic [3:0]           idx, idx_nxt;
    logic [63:0]          mem [DEPTH];
    logic [63:0]          head;
    logic [INFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [INFO_AW:0]     count;
    logic                 fifo_empty, fifo_full, push, pop, xfer, emit;
    logic [7:0]           hdr_byte, emit_byte;
    assign fifo_empty = count == '0;
    assign fifo_full  = count == (INFO_AW+1)'(DEPTH);
    assign head       = mem[rd_ptr];
    assign xfer       = i_valid & o_ready;
    assign push       = i_info_en & (~fifo_full | pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: if (i_valid) begin
                state_nxt = HEADER;
                idx_nxt   = '0;
            end
            HEADER: begin
                state_nxt = idx == 4'd9 ? BODY : HEADER;
                idx_nxt   = idx == 4'd9 ? 4'd0 : idx + 4'd1;
            end
            BODY: if (xfer & i_last) begin
                state_nxt = fifo_empty ? WAIT_INFO : TRAILER;
                idx_nxt   = '0;
            end
            WAIT_INFO: if (!fifo_empty) begin
                state_nxt = TRAILER;
                idx_nxt   = '0;
            end
            TRAILER: begin
                state_nxt = idx == 4'd7 ? IDLE : TRAILER;
                idx_nxt   = idx == 4'd7 ? 4'd0 : idx + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        o_ready   = state == BODY;
        hdr_byte  = idx == 4'd0 ? 8'h1F : idx == 4'd1 ? 8'h8B : idx == 4'd2 ? 8'h08 :
                    idx == 4'd9 ? OS_BYTE : 8'h00;
        emit      = state == HEADER || state == TRAILER || xfer;
        emit_byte = state == HEADER ? hdr_byte :
                    state == TRAILER ? head[{idx[2:0], 3'b000} +: 8] : i_byte;
        pop       = state == TRAILER && idx == 4'd7;
    end
    // Output registers give the fixed one-cycle latency; the FIFO shares the same reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_en       <= 1'b0;
            o_byte     <= 8'h00;
            o_eos      <= 1'b0;
            o_overflow <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            o_en   <= emit;
            o_byte <= emit ? emit_byte : 8'h00;
            o_eos  <= pop;
            if (i_info_en & fifo_full & ~pop) o_overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (INFO_AW+1)'(push) - (INFO_AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_info_len, i_info_crc};
    end
endmodule

// File: tb/tb_gzip_member_framer.sv
// tb_gzip_member_framer: scoreboard bench; expected bytes queued by stimulus, popped by an output monitor.
module tb_gzip_member_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_info_en = 1'b0;
    logic [31:0] i_info_len = '0;
    logic [31:0] i_info_crc = '0;
    logic        i_valid = 1'b0;
    logic        i_last = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        o_ready, o_en, o_eos, o_overflow;
    logic [7:0]  o_byte;
    logic [8:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          eos_cyc = 0;
    int          gap = 0;
    bit          after_eos = 0;

    gzip_member_framer dut (
        .clk(clk), .rst(rst), .i_info_en(i_info_en), .i_info_len(i_info_len),
        .i_info_crc(i_info_crc), .i_valid(i_valid), .i_last(i_last), .i_byte(i_byte),
        .o_ready(o_ready), .o_en(o_en), .o_byte(o_byte), .o_eos(o_eos), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (o_en === 1'b1) begin
            en_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got eos=%0b byte=%02h want none", o_eos, o_byte);
            end else begin
                e = exp_q.pop_front();
                if ({o_eos, o_byte} !== e) begin
                    errors++;
                    $display("FAIL out_byte got eos=%0b byte=%02h want eos=%0b byte=%02h",
                             o_eos, o_byte, e[8], e[7:0]);
                end
            end
            if (after_eos) begin
                gap = cyc - eos_cyc;
                after_eos = 0;
            end
            if (o_eos) begin
                eos_cyc = cyc;
                after_eos = 1;
            end
        end else begin
            checks++;
            if (o_eos !== 1'b0) begin
                errors++;
                $display("FAIL eos_without_en got %0b want 0", o_eos);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic exp_header();
        logic [7:0] h [10] = '{8'h1F, 8'h8B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, h[i]});
    endtask

    task automatic exp_trailer(input logic [31:0] len, input logic [31:0] crc, input int n);
        logic [63:0] t;
        t = {len, crc};
        for (int i = 0; i < n; i++) exp_q.push_back({i == 7, t[i*8 +: 8]});
    endtask

    task automatic exp_member(input logic [7:0] b, input logic [31:0] len, input logic [31:0] crc);
        exp_header();
        exp_q.push_back({1'b0, b});
        exp_trailer(len, crc, 8);
    endtask

    task automatic push_info(input logic [31:0] len, input logic [31:0] crc);
        i_info_en = 1'b1;
        i_info_len = len;
        i_info_crc = crc;
        step();
        i_info_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        i_valid = 1'b1;
        i_byte = b;
        i_last = last;
        while (!o_ready && n < 200) begin
            step();
            n++;
        end
        chk("ready_timeout", {31'd0, o_ready}, 32'd1);
        step();
        i_valid = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        step();
        chk("drain_queue_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_o_en", {31'd0, o_en}, 0);
        chk("rst_o_eos", {31'd0, o_eos}, 0);
        chk("rst_o_ready", {31'd0, o_ready}, 0);
        chk("rst_o_overflow", {31'd0, o_overflow}, 0);
        chk("rst_o_byte", {24'd0, o_byte}, 0);
    endtask

    initial begin
        int en0;
        do_reset();

        // basic member
        en0 = en_cnt;
        exp_header();
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b0, 8'hBB});
        exp_q.push_back({1'b0, 8'hCC});
        exp_trailer(32'd5, 32'h3610A686, 8);
        push_info(32'd5, 32'h3610A686);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        drain();
        chk("basic_en_count", en_cnt - en0, 21);

        // late info: park in WAIT_INFO, trailer two cycles after the push
        exp_header();
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_trailer(32'd2, 32'hDEADBEEF, 8);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("wait_ready", {31'd0, o_ready}, 0);
            chk("wait_en", {31'd0, o_en}, 0);
        end
        push_info(32'd2, 32'hDEADBEEF);
        chk("late_en_p1", {31'd0, o_en}, 0);
        step();
        chk("late_en_p2", {31'd0, o_en}, 0);
        step();
        chk("late_en_p3", {31'd0, o_en}, 1);
        chk("late_first_byte", {24'd0, o_byte}, 32'hEF);
        drain();

        // back-to-back members
        exp_header();
        exp_q.push_back({1'b0, 8'h01});
        exp_trailer(32'd1, 32'h11223344, 8);
        exp_header();
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h03});
        exp_trailer(32'd2, 32'h55667788, 8);
        push_info(32'd1, 32'h11223344);
        push_info(32'd2, 32'h55667788);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        drain();
        chk("b2b_idle_gap", gap, 2);

        // overflow: fifth push dropped, first four intact
        for (int i = 0; i < 5; i++) begin
            push_info(32'h10 + i, 32'hC0DE0000 + i);
            chk("ovf_flag", {31'd0, o_overflow}, (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_member(8'h40 + 8'(i), 32'h10 + i, 32'hC0DE0000 + i);
            send_byte(8'h40 + 8'(i), 1'b1);
        end
        drain();
        chk("ovf_sticky", {31'd0, o_overflow}, 1);
        do_reset();

        // full FIFO with push coinciding with the trailer pop
        for (int i = 0; i < 4; i++) push_info(32'h100 + i, 32'hF00D0000 + i);
        exp_member(8'h60, 32'h100, 32'hF00D0000);
        send_byte(8'h60, 1'b1);
        repeat (7) step();
        push_info(32'h1FF, 32'hBEEF0005);
        chk("fullpp_no_ovf", {31'd0, o_overflow}, 0);
        for (int i = 1; i < 5; i++) begin
            exp_member(8'h60 + 8'(i), (i == 4) ? 32'h1FF : 32'h100 + i,
                       (i == 4) ? 32'hBEEF0005 : 32'hF00D0000 + i);
            send_byte(8'h60 + 8'(i), 1'b1);
        end
        drain();
        chk("fullpp_no_ovf_end", {31'd0, o_overflow}, 0);

        // reset at trailer idx 3 truncates and empties the FIFO
        exp_header();
        exp_q.push_back({1'b0, 8'h55});
        exp_trailer(32'h7, 32'hCAFEF00D, 3);
        push_info(32'h7, 32'hCAFEF00D);
        send_byte(8'h55, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_en", {31'd0, o_en}, 0);
        chk("mid_rst_eos", {31'd0, o_eos}, 0);
        chk("mid_rst_ready", {31'd0, o_ready}, 0);
        exp_member(8'h77, 32'h9, 32'h12345678);
        send_byte(8'h77, 1'b1);
        repeat (4) begin
            step();
            chk("post_rst_parked", {31'd0, o_en}, 0);
        end
        push_info(32'h9, 32'h12345678);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gzip_member_framer.md
# gzip_member_framer

Sequences one gzip member around a raw deflate byte stream. It emits the 10-byte gzip header, passes the deflate bytes through, and appends the 8-byte trailer (CRC32, ISIZE). The length/CRC of the uncompressed data arrives on a separate info port, typically earlier than the end of the compressed stream, so it is queued in a small FIFO. The block sits between the deflate encoder and the byte sink, with the length/CRC calculator feeding its info port.

## Interface

- `INFO_AW`, default 2: log2 of the info-FIFO depth (4 entries).
- `OS_BYTE`, default 8'hFF: gzip OS field.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `i_info_en`  in  1: pulse; pushes (`i_info_len`, `i_info_crc`) into the info FIFO.
- `i_info_len`  in  32: uncompressed byte count, i.e. ISIZE.
- `i_info_crc`  in  32: final (already inverted) CRC32.
- `i_valid`  in  1: deflate byte valid.
- `i_last`  in  1: qualifies the final deflate byte of the member.
- `i_byte`  in  8: deflate byte.
- `o_ready`  out  1: framer accepts `i_byte`. Transfer occurs when `i_valid & o_ready`. Combinational from state.
- `o_en`  out  1: output byte strobe. No downstream backpressure.
- `o_byte`  out  8: output byte.
- `o_eos`  out  1: with `o_en`, marks the last trailer byte of a member.
- `o_overflow`  out  1: sticky; set when an info push is dropped.

## Operation

- **States:** IDLE, HEADER, BODY, WAIT_INFO, TRAILER. There is a 4-bit byte index `idx`.
- **IDLE**
  - `o_ready`=0.
  - If `i_valid`=1: go to HEADER with `idx`=0.
- **HEADER**
  - `o_ready`=0.
  - Emits 1F 8B 08 00 00 00 00 00 00 `OS_BYTE`, one byte per cycle, in `idx` order.
  - After `idx`=9: go to BODY.
- **BODY**
  - `o_ready`=1. Each transfer forwards `i_byte`.
  - A transfer with `i_last`=1 leaves BODY: to TRAILER (`idx`=0) if the FIFO is non-empty, else to WAIT_INFO.
- **WAIT_INFO**
  - `o_ready`=0, no output.
  - Go to TRAILER (`idx`=0) in the cycle after the FIFO becomes non-empty.
- **TRAILER**
  - `o_ready`=0.
  - Emits the FIFO head `crc[7:0]`, `crc[15:8]`, `crc[23:16]`, `crc[31:24]`, `len[7:0]` … `len[31:24]`, for `idx` 0..7.
  - At `idx`=7: pop the FIFO, flag `o_eos`, go to IDLE.
- **Info FIFO**
  - Depth 2^`INFO_AW`, 64-bit entries, wrap-around pointers, plus a count of width `INFO_AW`+1.
  - Push when `i_info_en`=1 and (not full, or a pop occurs in the same cycle).
  - Push while full with no pop: entry dropped, `o_overflow`←1. Nothing else changes.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - A pop never happens on empty, because TRAILER is only entered when non-empty.
- **Protocol violations:** `i_last` outside BODY is ignored, since no transfer is possible there.

## Timing

- All outputs except `o_ready` are registered.
  - A byte produced in state cycle N (header/trailer index or BODY transfer) appears on `o_en`/`o_byte` at cycle N+1.
  - Latency is exactly 1 cycle.
- Cycle accounting:
  - IDLE costs one cycle; the first header byte is driven the cycle after HEADER is entered.
  - Member overhead without stalls is 1 + 10 + 8 = 19 cycles plus the body bytes.
  - There is no gap between the header and the first body byte if `i_valid` is held.
- Info push while the FIFO is empty, in the same cycle as the `i_last` transfer: go to WAIT_INFO, then TRAILER one cycle later.
- **Reset** (`rst`=1 at a clock edge):
  - State←IDLE, `idx`←0, FIFO emptied.
  - `o_en`←0, `o_byte`←0, `o_eos`←0, `o_overflow`←0.
  - `o_ready` is 0 from the next cycle.
  - Reset mid-member truncates output immediately; no trailer is emitted.
- `o_eos`=1 only in the same cycle as `o_en`=1 with the final ISIZE byte.

## Test plan

- **Basic member:** info (len=5, crc=0x3610A686) pushed, then 3 deflate bytes AA BB CC with `i_last` on CC.
  - Output: 1F 8B 08 00 00 00 00 00 00 FF AA BB CC 86 A6 10 36 05 00 00 00.
  - `o_eos` only on the final 00. 21 `o_en` pulses.
- **Late info:** deflate bytes ending with `i_last` first, info pushed 7 cycles later.
  - Block parks in WAIT_INFO with `o_ready`=0, no `o_en`.
  - Trailer starts 2 cycles after the push.
- **Back-to-back members:** two info entries (len=1/crc=0x11223344, len=2/crc=0x55667788) queued first.
  - Trailers emitted in FIFO order.
  - Second header begins after exactly one IDLE cycle.
- **Overflow:** 5 info pushes with no pops, depth 4.
  - `o_overflow`=1 after the 5th push and stays 1.
  - The first 4 entries are preserved and emitted intact.
- **Full push+pop:** FIFO full, push coinciding with the TRAILER `idx`=7 pop.
  - No overflow, count stays 4, the new entry is emitted last.
- **Reset mid-trailer:** `rst` at trailer `idx`=3.
  - Next cycle `o_en`=0, `o_eos`=0, `o_ready`=0, FIFO empty.
  - A new member then frames correctly.
